// File: rtl/addr_assembler_bus.sv
// -----------------------------------------------------------------------------
// addr_assembler_bus
//
// Memory-side request queue. Cache requests arrive as tag / index / block
// offset fields plus a read or write command. The full byte address is
// rebuilt by concatenating the fields, and each request is queued in a small
// FIFO. Queued requests are issued one at a time on the memory bus with a
// cmd/ack handshake.
//
// Optional feature (macro BUS_TIMEOUT_EN): a bus wait limit. A command left
// unacknowledged for TIMEOUT_CYCLES cycles is dropped, and bus_timeout pulses.
// With the macro undefined the bus waits forever and bus_timeout is tied 0.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid      request present
//   req_ready      queue can accept (not full, from the registered count)
//   req_rd/req_wr  command; exactly one must be high for a legal request
//   tag_in, index_in, blk_offset_in   address fields
//   bus_cmd_rd/bus_cmd_wr  bus command, held until bus_ack
//   bus_address    reassembled address of the command being issued
//   bus_ack        bus accepts the current command
//   err_cmd        one-cycle pulse: an illegal command was dropped
//   bus_timeout    one-cycle pulse: a command was dropped after the wait limit
//   fifo_count     occupied queue entries
// -----------------------------------------------------------------------------
module addr_assembler_bus #(
  parameter int ADDR_WID       = 32,
  parameter int TAG_MSB        = 31,
  parameter int TAG_LSB        = 20,
  parameter int INDEX_MSB      = 19,
  parameter int INDEX_LSB      = 2,
  parameter int OFFSET_MSB     = 1,
  parameter int OFFSET_LSB     = 0,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_rd,
  input  logic                          req_wr,
  input  logic [TAG_MSB:TAG_LSB]        tag_in,
  input  logic [INDEX_MSB:INDEX_LSB]    index_in,
  input  logic [OFFSET_MSB:OFFSET_LSB]  blk_offset_in,
  output logic                          bus_cmd_rd,
  output logic                          bus_cmd_wr,
  output logic [ADDR_WID-1:0]           bus_address,
  input  logic                          bus_ack,
  output logic                          err_cmd,
  output logic                          bus_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_WID:0]   fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wasNonEmpty_q;
  logic                errCmd_q;

  logic                cmdLegal;
  logic                reqFire;
  logic                doPush;
  logic                doPop;
  logic                timeoutHit;
  logic [ADDR_WID:0]   headEntry;
  logic [ADDR_WID-1:0] assembledAddr;

  // The fields tile the address exactly, so assembly is pure wiring.
  assign assembledAddr = {tag_in, index_in, blk_offset_in};

  // Readiness comes only from the registered count, so a pop in the same
  // cycle never opens room for a push.
  assign req_ready = (count_q != FULL_COUNT);
  assign cmdLegal  = req_rd ^ req_wr;
  assign reqFire   = req_valid && req_ready;
  assign doPush    = reqFire && cmdLegal;
  assign headEntry = fifoMem_q[rdPtr_q];

  assign fifo_count = count_q;
  assign err_cmd    = errCmd_q;

`ifdef BUS_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] LAST_WAIT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer_q;
  logic             timeout_q;

  // timer_q counts completed BUSY cycles of the current command; the IDLE
  // cycle that always precedes BUSY clears it. An ack in the last allowed
  // cycle takes priority over the timeout.
  assign timeoutHit  = (state_q == BUSY) && !bus_ack && (timer_q == LAST_WAIT);
  assign bus_timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= (state_q == BUSY) ? timer_q + 1'b1 : '0;
      timeout_q <= timeoutHit;
    end
  end
`else
  logic unusedTimeoutParam;

  assign timeoutHit         = 1'b0;
  assign bus_timeout        = 1'b0;
  assign unusedTimeoutParam = (TIMEOUT_CYCLES != 0);
`endif

  // Pointer and occupancy update. Pointers wrap naturally because the depth
  // is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Bus FSM. IDLE leaves only once the queue has been non-empty for a full
  // cycle: a fresh entry spends one cycle in the FIFO and one IDLE cycle
  // before it is issued, and consecutive commands are always separated by an
  // IDLE cycle. In BUSY the command is taken from the FIFO head, which cannot
  // change until the pop.
  always_comb begin
    state_d     = state_q;
    doPop       = 1'b0;
    bus_cmd_rd  = 1'b0;
    bus_cmd_wr  = 1'b0;
    bus_address = '0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && wasNonEmpty_q) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        bus_cmd_rd  = headEntry[ADDR_WID];
        bus_cmd_wr  = !headEntry[ADDR_WID];
        bus_address = headEntry[ADDR_WID-1:0];
        if (bus_ack || timeoutHit) begin
          doPop   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers. Reset drops any in-flight command immediately because
  // the bus outputs are decoded from the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      wasNonEmpty_q <= 1'b0;
      errCmd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      wasNonEmpty_q <= (count_q != '0);
      errCmd_q      <= reqFire && !cmdLegal;
    end
  end

  // Queue storage holds {is_rd, address}; contents need no reset because the
  // count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (doPush) begin
      fifoMem_q[wrPtr_q] <= {req_rd, assembledAddr};
    end
  end

endmodule

// File: tb/tb_addr_assembler_bus.sv
module tb_addr_assembler_bus;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:20] tag_in = '0;
  logic [19:2]  index_in = '0;
  logic [1:0]   blk_offset_in = '0;
  logic        bus_cmd_rd;
  logic        bus_cmd_wr;
  logic [31:0] bus_address;
  logic        bus_ack = 1'b0;
  logic        err_cmd;
  logic        bus_timeout;
  logic [2:0]  fifo_count;

  int passCount = 0;
  int totalCount = 0;

  addr_assembler_bus dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd(req_rd),
    .req_wr(req_wr),
    .tag_in(tag_in),
    .index_in(index_in),
    .blk_offset_in(blk_offset_in),
    .bus_cmd_rd(bus_cmd_rd),
    .bus_cmd_wr(bus_cmd_wr),
    .bus_address(bus_address),
    .bus_ack(bus_ack),
    .err_cmd(err_cmd),
    .bus_timeout(bus_timeout),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Single place where a comparison is counted and reported.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic rd, input logic wr,
                               input logic [11:0] tag, input logic [17:0] idx,
                               input logic [1:0] off);
    req_valid     = valid;
    req_rd        = rd;
    req_wr        = wr;
    tag_in        = tag;
    index_in      = idx;
    blk_offset_in = off;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 18'h00000, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: a queue of requests plus a bus that is either idle
  // or serving the queue head. An idle bus picks up the head once the queue
  // has held something during both of the last two cycles.
  typedef struct packed {
    logic        isRd;
    logic [31:0] addr;
  } req_t;

  req_t mq[$];
  bit   mBusy = 1'b0;
  bit   mSeen = 1'b0;
  bit   mErr = 1'b0;
  bit   mTo = 1'b0;
  int   mBusyCycles = 0;

  initial forever begin
    bit ready, legal, doPush, doPop, timedOut, nonEmpty;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      mBusy = 1'b0;
      mSeen = 1'b0;
      mErr = 1'b0;
      mTo = 1'b0;
      mBusyCycles = 0;
    end else begin
      ready    = mq.size() < DEPTH;
      legal    = (req_rd != req_wr);
      doPush   = req_valid && ready && legal;
      timedOut = TO_EN && mBusy && !bus_ack && (mBusyCycles == TIMEOUT);
      doPop    = mBusy && (bus_ack || timedOut);
      nonEmpty = mq.size() != 0;
      mErr     = req_valid && ready && !legal;
      mTo      = timedOut;
      if (mBusy) begin
        if (doPop) mBusy = 1'b0;
        else mBusyCycles++;
      end else if (nonEmpty && mSeen) begin
        mBusy = 1'b1;
        mBusyCycles = 1;
      end
      if (doPop) void'(mq.pop_front());
      if (doPush) mq.push_back({req_rd, tag_in, index_in, blk_offset_in});
      mSeen = nonEmpty;
    end
  end

  // Every-cycle comparison of all outputs against the reference.
  initial forever begin
    logic eBusy;
    req_t head;
    @(negedge clk);
    eBusy = 1'b0;
    head  = '0;
    if (mBusy && mq.size() != 0) begin
      eBusy = 1'b1;
      head  = mq[0];
    end
    checkOutput("cmp bus_cmd_rd", bus_cmd_rd, eBusy && head.isRd);
    checkOutput("cmp bus_cmd_wr", bus_cmd_wr, eBusy && !head.isRd);
    checkOutput("cmp bus_address", bus_address, eBusy ? head.addr : 32'h0);
    checkOutput("cmp fifo_count", fifo_count, 32'(mq.size()));
    checkOutput("cmp req_ready", req_ready, mq.size() < DEPTH);
    checkOutput("cmp err_cmd", err_cmd, mErr);
    checkOutput("cmp bus_timeout", bus_timeout, mTo);
  end

  initial begin
    int hi;
    // Reset state
    #3;
    checkOutput("reset req_ready", req_ready, 1);
    checkOutput("reset bus_cmd_rd", bus_cmd_rd, 0);
    checkOutput("reset bus_cmd_wr", bus_cmd_wr, 0);
    checkOutput("reset bus_address", bus_address, 0);
    checkOutput("reset fifo_count", fifo_count, 0);
    checkOutput("reset err_cmd", err_cmd, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single read: issued two edges after the push, held until ack
    applyStimulus(1'b1, 1'b1, 1'b0, 12'hFFF, 18'h3C000, 2'b00);
    tick();
    checkOutput("t1 count after push", fifo_count, 1);
    applyIdle();
    tick();
    checkOutput("t1 no cmd one edge after push", bus_cmd_rd, 0);
    tick();
    checkOutput("t1 rd issued", bus_cmd_rd, 1);
    checkOutput("t1 wr low", bus_cmd_wr, 0);
    checkOutput("t1 address", bus_address, 32'hFFFF_0000);
    tick();
    checkOutput("t1 rd held c2", bus_cmd_rd, 1);
    tick();
    checkOutput("t1 rd held c3", bus_cmd_rd, 1);
    checkOutput("t1 address held c3", bus_address, 32'hFFFF_0000);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checkOutput("t1 rd dropped after ack", bus_cmd_rd, 0);
    checkOutput("t1 count after ack", fifo_count, 0);

    // Two writes in order with an idle cycle between them
    applyStimulus(1'b1, 1'b0, 1'b1, 12'hABC, 18'h3772E, 2'b10);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h233, 18'h0C8CC, 2'b11);
    tick();
    applyIdle();
    tick();
    checkOutput("t2 first wr", bus_cmd_wr, 1);
    checkOutput("t2 first address", bus_address, 32'hABCD_DCBA);
    checkOutput("t2 count two", fifo_count, 2);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checkOutput("t2 idle gap", bus_cmd_wr, 0);
    checkOutput("t2 count one", fifo_count, 1);
    tick();
    checkOutput("t2 second wr", bus_cmd_wr, 1);
    checkOutput("t2 second address", bus_address, 32'h2333_2333);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checkOutput("t2 count empty", fifo_count, 0);

    // Illegal commands: both high, then both low
    applyStimulus(1'b1, 1'b1, 1'b1, 12'h111, 18'h00001, 2'b01);
    tick();
    checkOutput("t3 err pulse 1", err_cmd, 1);
    applyIdle();
    tick();
    checkOutput("t3 err low", err_cmd, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h222, 18'h00002, 2'b10);
    tick();
    checkOutput("t3 err pulse 2", err_cmd, 1);
    applyIdle();
    tick();
    checkOutput("t3 err low again", err_cmd, 0);
    checkOutput("t3 count zero", fifo_count, 0);
    tick();
    checkOutput("t3 no rd", bus_cmd_rd, 0);
    checkOutput("t3 no wr", bus_cmd_wr, 0);

    // Fill the queue: the fifth push is refused
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 12'(i + 1), 18'(i * 3), 2'b01);
      tick();
      checkOutput("t4 count", fifo_count, (i < 4) ? i + 1 : 4);
    end
    checkOutput("t4 ready low", req_ready, 0);
    applyIdle();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checkOutput("t4 count after ack", fifo_count, 3);
    checkOutput("t4 ready back", req_ready, 1);

    // Reset while busy with entries queued
    tick();
    checkOutput("t5 busy again", bus_cmd_rd, 1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    checkOutput("t5 busy with two", fifo_count, 2);
    checkOutput("t5 rd high", bus_cmd_rd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5 rd dropped in reset", bus_cmd_rd, 0);
    checkOutput("t5 address cleared", bus_address, 0);
    checkOutput("t5 count cleared", fifo_count, 0);
    checkOutput("t5 ready in reset", req_ready, 1);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checkOutput("t5 nothing issued", bus_cmd_rd | bus_cmd_wr, 0);
    checkOutput("t5 still empty", fifo_count, 0);

`ifdef BUS_TIMEOUT_EN
    // Timeout: no ack drops the head after the wait limit
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h5A5, 18'h12345, 2'b11);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h3C3, 18'h0F0F0, 2'b00);
    tick();
    applyIdle();
    for (int i = 0; i < 10 && !bus_cmd_rd; i++) tick();
    checkOutput("t6 first issued", bus_cmd_rd, 1);
    hi = 0;
    while (bus_cmd_rd && hi < 40) begin
      hi++;
      tick();
    end
    checkOutput("t6 cycles held", hi, TIMEOUT);
    checkOutput("t6 timeout pulse", bus_timeout, 1);
    checkOutput("t6 count after drop", fifo_count, 1);
    tick();
    checkOutput("t6 timeout ends", bus_timeout, 0);
    checkOutput("t6 second issued", bus_cmd_wr, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checkOutput("t6 wr still held", bus_cmd_wr, 1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checkOutput("t6 ack wins no timeout", bus_timeout, 0);
    checkOutput("t6 wr done", bus_cmd_wr, 0);
    checkOutput("t6 empty", fifo_count, 0);
`else
    // Without the wait limit the command stays up indefinitely
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h5A5, 18'h12345, 2'b11);
    tick();
    applyIdle();
    repeat (TIMEOUT + 6) tick();
    checkOutput("t6 wr waits forever", bus_cmd_wr, 1);
    checkOutput("t6 no timeout", bus_timeout, 0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checkOutput("t6 empty", fifo_count, 0);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
